// File: rtl/cpu_pkg.sv
// Shared datapath constants: bus width, register index encoding (identical to
// the bus multiplexer r_out select) and the program-counter reset value.
package cpu_pkg;

  localparam int DW        = 16;
  localparam int REG_IDX_W = 3;

  // Register indices, same encoding as the mux r_out select field.
  localparam logic [REG_IDX_W-1:0] R0_IDX = 3'd0;
  localparam logic [REG_IDX_W-1:0] R1_IDX = 3'd1;
  localparam logic [REG_IDX_W-1:0] R2_IDX = 3'd2;
  localparam logic [REG_IDX_W-1:0] R3_IDX = 3'd3;
  localparam logic [REG_IDX_W-1:0] R4_IDX = 3'd4;
  localparam logic [REG_IDX_W-1:0] R5_IDX = 3'd5;
  localparam logic [REG_IDX_W-1:0] R6_IDX = 3'd6;
  localparam logic [REG_IDX_W-1:0] R7_IDX = 3'd7;

  // r7 doubles as the program counter.
  localparam logic [REG_IDX_W-1:0] PC_IDX = R7_IDX;

  localparam logic [DW-1:0] PC_RST = 16'h0000;

  // Converts a loop index into the select-field encoding.
  function automatic logic [REG_IDX_W-1:0] reg_idx(input int unsigned i);
    logic [31:0] v;
    v = i;
    return v[REG_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/bus_reg_bank_reg_en16.sv
// reg_en16: W-bit register with load enable and an asynchronous active-low
// reset that forces the RST_VAL constant.
module reg_en16 #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d on a rising edge when load is high; reset wins immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bus_reg_bank.sv
// bus_reg_bank: write side of the shared datapath bus. Captures buswires into
// r0..r7, A and IR, and the ALU result into G. r7 is the program counter and
// has its own increment path; a bus write to r7 beats a same-cycle increment.
//
// Load strobes (r_in_en, a_in, ir_in, g_in, incr_pc) are single-cycle
// commands from the control FSM with no backpressure: a strobe sampled high
// on a rising edge always takes effect on that edge, and the new value is
// visible on the registered outputs right after it. Strobes are independent
// and may be combined freely in one cycle.
//
// Optional build macro WR_TRACE_EN adds last_wr_idx and wr_count outputs that
// trace general-register writes.
module bus_reg_bank
  import cpu_pkg::*;
#(
  parameter int              DW     = cpu_pkg::DW,
  parameter int              NREG   = 8,
  parameter logic [DW-1:0]   PC_RST = cpu_pkg::PC_RST
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        buswires,
  input  logic                 r_in_en,
  input  logic [REG_IDX_W-1:0] r_in_sel,
  input  logic                 a_in,
  input  logic                 ir_in,
  input  logic                 g_in,
  input  logic [DW-1:0]        alu_result,
  input  logic                 incr_pc,
  output logic [DW-1:0]        r0,
  output logic [DW-1:0]        r1,
  output logic [DW-1:0]        r2,
  output logic [DW-1:0]        r3,
  output logic [DW-1:0]        r4,
  output logic [DW-1:0]        r5,
  output logic [DW-1:0]        r6,
  output logic [DW-1:0]        r7,
  output logic [DW-1:0]        a_q,
  output logic [DW-1:0]        g_q,
  output logic [DW-1:0]        ir_q
`ifdef WR_TRACE_EN
  ,
  output logic [3:0]           last_wr_idx,
  output logic [15:0]          wr_count
`endif
);

  logic [NREG-1:0] r_ld;
  logic [DW-1:0]   gp_q [NREG-1];
  logic [DW-1:0]   pc_q;

  // One-hot write decode. The enable gates every term, so an unknown select
  // with r_in_en low cannot raise any load.
  always_comb begin
    r_ld = '0;
    for (int i = 0; i < NREG; i++) begin
      r_ld[i] = r_in_en && (r_in_sel == reg_idx(i));
    end
  end

  // r0..r6 are plain load-enable registers.
  for (genvar gi = 0; gi < NREG - 1; gi++) begin : g_gp
    reg_en16 #(.W(DW), .RST_VAL('0)) u_gp (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (r_ld[gi]),
      .d     (buswires),
      .q     (gp_q[gi])
    );
  end

  // r7 / program counter: bus write has priority over increment; increment
  // wraps modulo 2^DW silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RST;
    end else if (r_ld[PC_IDX]) begin
      pc_q <= buswires;
    end else if (incr_pc) begin
      pc_q <= pc_q + DW'(1);
    end
  end

  reg_en16 #(.W(DW), .RST_VAL('0)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (a_in),
    .d     (buswires),
    .q     (a_q)
  );

  reg_en16 #(.W(DW), .RST_VAL('0)) u_ir (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ir_in),
    .d     (buswires),
    .q     (ir_q)
  );

  reg_en16 #(.W(DW), .RST_VAL('0)) u_g (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (g_in),
    .d     (alu_result),
    .q     (g_q)
  );

  assign r0 = gp_q[R0_IDX];
  assign r1 = gp_q[R1_IDX];
  assign r2 = gp_q[R2_IDX];
  assign r3 = gp_q[R3_IDX];
  assign r4 = gp_q[R4_IDX];
  assign r5 = gp_q[R5_IDX];
  assign r6 = gp_q[R6_IDX];
  assign r7 = pc_q;

`ifdef WR_TRACE_EN
  // Trace general writes: remember the last index (MSB marks "valid") and a
  // saturating count of write cycles. PC increments alone are not writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr_idx <= 4'b0000;
      wr_count    <= 16'h0000;
    end else if (r_in_en) begin
      last_wr_idx <= {1'b1, r_in_sel};
      if (wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'h0001;
      end
    end
  end
`endif

endmodule
